// File: rtl/s27_array.sv
// rtl/s27_array.sv - multi-lane s27 benchmark core with one shared mux-D scan chain
//
// s27_lane : combinational next-state/output logic of one s27 core
//    g0..g3        primary inputs of the lane
//    g5, g6, g7    current state of the lane
//    g10, g11, g13 functional next state for g5, g6, g7
//    g17           primary output
//
// s27_array : CHANNELS independent s27 lanes with scan and enable
//    CK   clock, all flops update on the rising edge
//    RN   synchronous active-low reset, clears every state flop
//    EN   functional state-update enable
//    SE   scan enable, shift mode; wins over EN
//    SI   scan data in, enters at lane 0 G5
//    G0..G3 [CHANNELS] per-lane primary inputs
//    G17  [CHANNELS] per-lane primary output, combinational
//    SO   scan data out, lane CHANNELS-1 G7 flop

module s27_lane (
   input  logic g0,
   input  logic g1,
   input  logic g2,
   input  logic g3,
   input  logic g5,
   input  logic g6,
   input  logic g7,
   output logic g10,
   output logic g11,
   output logic g13,
   output logic g17
);

   logic g8;
   logic g9;
   logic g12;
   logic g14;
   logic g15;
   logic g16;

   // Gate-for-gate copy of the original netlist so equivalence flows see
   // the same structure as the single-lane benchmark.
   assign g14 = ~g0;
   assign g12 = ~(g1 | g7);
   assign g13 = ~(g2 | g12);
   assign g8  = g14 & g6;
   assign g15 = g12 | g8;
   assign g16 = g3 | g8;
   assign g9  = ~(g16 & g15);
   assign g11 = ~(g5 | g9);
   assign g10 = ~(g14 | g11);
   assign g17 = ~g11;

endmodule

module s27_array #(
   parameter int CHANNELS = 4
) (
   input  logic                CK,
   input  logic                RN,
   input  logic                EN,
   input  logic                SE,
   input  logic                SI,
   input  logic [CHANNELS-1:0] G0,
   input  logic [CHANNELS-1:0] G1,
   input  logic [CHANNELS-1:0] G2,
   input  logic [CHANNELS-1:0] G3,
   output logic [CHANNELS-1:0] G17,
   output logic                SO
);

   logic [CHANNELS-1:0] g5;
   logic [CHANNELS-1:0] g6;
   logic [CHANNELS-1:0] g7;
   logic [CHANNELS-1:0] g10;
   logic [CHANNELS-1:0] g11;
   logic [CHANNELS-1:0] g13;
   logic [CHANNELS-1:0] scan_g5;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      s27_lane u_lane (
         .g0  (G0[i]),
         .g1  (G1[i]),
         .g2  (G2[i]),
         .g3  (G3[i]),
         .g5  (g5[i]),
         .g6  (g6[i]),
         .g7  (g7[i]),
         .g10 (g10[i]),
         .g11 (g11[i]),
         .g13 (g13[i]),
         .g17 (G17[i])
      );
   end

   // Shift source for each lane's G5: SI for lane 0, otherwise the G7 of
   // the previous lane. G6 and G7 always shift from G5 and G6 of the same lane.
   always_comb begin
      scan_g5    = '0;
      scan_g5[0] = SI;
      for (int i = 1; i < CHANNELS; i++) begin
         scan_g5[i] = g7[i-1];
      end
   end

   always_ff @(posedge CK) begin
      if (!RN) begin
         g5 <= '0;
         g6 <= '0;
         g7 <= '0;
      end else if (SE) begin
         g5 <= scan_g5;
         g6 <= g5;
         g7 <= g6;
      end else if (EN) begin
         g5 <= g10;
         g6 <= g11;
         g7 <= g13;
      end
   end

   assign SO = g7[CHANNELS-1];

endmodule

// File: tb/tb_s27_array.sv
// tb/tb_s27_array.sv - scoreboard bench for s27_array with 4- and 8-lane instances

module tb_s27_array;

   logic CK = 1'b0;
   logic RN, EN, SE, SI;
   logic [3:0] a0, a1, a2, a3, a17;
   logic [7:0] b0, b1, b2, b3, b17;
   logic       aso, bso;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] ea17;
      logic       easo;
      logic [7:0] eb17;
      logic       ebso;
   } exp_t;

   exp_t q[$];

   // Reference chain state: index 3*lane + {0:G5, 1:G6, 2:G7}, SI enters at 0.
   logic [11:0] ma;
   logic [23:0] mb;

   int pat[12] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 0};

   always #5 CK = ~CK;

   s27_array #(.CHANNELS(4)) u_dut4 (
      .CK(CK), .RN(RN), .EN(EN), .SE(SE), .SI(SI),
      .G0(a0), .G1(a1), .G2(a2), .G3(a3), .G17(a17), .SO(aso)
   );

   s27_array #(.CHANNELS(8)) u_dut8 (
      .CK(CK), .RN(RN), .EN(EN), .SE(SE), .SI(SI),
      .G0(b0), .G1(b1), .G2(b2), .G3(b3), .G17(b17), .SO(bso)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // One s27 lane from its boolean rules. s = {G7,G6,G5}.
   // Returns {G17, G7next, G6next, G5next}.
   function automatic logic [3:0] ref_lane(input logic [2:0] s, input logic x0, x1, x2, x3);
      logic nor17, gp, bad, keep;
      nor17 = !(x1 || s[2]);
      gp    = !x0 && s[1];
      bad   = !((x3 || gp) && (nor17 || gp));
      keep  = !(s[0] || bad);
      return {!keep, !(x2 || nor17), keep, x0 && !keep};
   endfunction

   always @(negedge CK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("g17_c4", 32'(a17), 32'(e.ea17));
         chk("so_c4",  32'(aso),  32'(e.easo));
         chk("g17_c8", 32'(b17), 32'(e.eb17));
         chk("so_c8",  32'(bso),  32'(e.ebso));
      end
   end

   // Drive one cycle just after a rising edge, queue what the outputs must
   // be during this cycle, advance the model, and return #1 after the edge.
   task automatic step(input logic rn, en, se, si);
      exp_t e;
      logic [11:0] na;
      logic [23:0] nb;
      logic [3:0]  r;
      RN = rn; EN = en; SE = se; SI = si;
      for (int i = 0; i < 4; i++) begin
         r = ref_lane(ma[3*i +: 3], a0[i], a1[i], a2[i], a3[i]);
         e.ea17[i] = r[3];
         na[3*i +: 3] = r[2:0];
      end
      for (int i = 0; i < 8; i++) begin
         r = ref_lane(mb[3*i +: 3], b0[i], b1[i], b2[i], b3[i]);
         e.eb17[i] = r[3];
         nb[3*i +: 3] = r[2:0];
      end
      e.easo = ma[11];
      e.ebso = mb[23];
      q.push_back(e);
      if (!rn) begin
         ma = '0;
         mb = '0;
      end else if (se) begin
         ma = {ma[10:0], si};
         mb = {mb[22:0], si};
      end else if (en) begin
         ma = na;
         mb = nb;
      end
      @(posedge CK);
      #1;
   endtask

   task automatic zero_inputs();
      a0 = '0; a1 = '0; a2 = '0; a3 = '0;
      b0 = '0; b1 = '0; b2 = '0; b3 = '0;
   endtask

   task automatic rand_inputs();
      a0 = 4'($urandom); a1 = 4'($urandom); a2 = 4'($urandom); a3 = 4'($urandom);
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
   endtask

   task automatic set_lane0(input logic x0, x1, x2, x3);
      a0[0] = x0; a1[0] = x1; a2[0] = x2; a3[0] = x3;
   endtask

   task automatic scan_dump();
      for (int k = 0; k < 24; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      zero_inputs();
      RN = 1'b0; EN = 1'b0; SE = 1'b0; SI = 1'b0;
      ma = '0;
      mb = '0;
      @(posedge CK);
      #1;

      // Reset hold, lane 0 G1=0 G3=1, then G3=0
      set_lane0(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst_g17_g3hi", 32'(a17[0]), 32'd0);
      chk("rst_so", 32'(aso), 32'd0);
      a3[0] = 1'b0;
      #1;
      chk("rst_g17_g3lo", 32'(a17[0]), 32'd1);

      // Idle fixpoint
      zero_inputs();
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("idle_g17", 32'(a17), 32'hf);

      // Lane 0 sequence, lanes 1..3 held at 0
      set_lane0(1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("seq_g17_first", 32'(a17[0]), 32'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      set_lane0(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      set_lane0(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      set_lane0(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      zero_inputs();
      scan_dump();

      // Scan shift pattern through the 12-flop chain
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 24; k++) begin
         step(1'b1, 1'b0, 1'b1, (k < 12) ? 1'(pat[k]) : 1'b0);
         if (k >= 11 && k < 23) chk("scan_so_pat", 32'(aso), 32'(pat[k-11]));
      end

      // Enable/priority from a random scanned-in state
      for (int k = 0; k < 24; k++) step(1'b1, 1'b0, 1'b1, 1'($urandom));
      for (int k = 0; k < 4; k++) begin
         rand_inputs();
         step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         rand_inputs();
         step(1'b1, 1'b1, 1'b1, 1'($urandom));
      end
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("rst_mid_shift_so", 32'(bso), 32'd0);
      zero_inputs();
      scan_dump();

      // Lane independence: only lane 5 of the 8-lane instance moves
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 100; k++) begin
         rand_inputs();
         b0 = b0 & 8'h20; b1 = b1 & 8'h20; b2 = b2 & 8'h20; b3 = b3 & 8'h20;
         step(1'b1, 1'b1, 1'b0, 1'b0);
      end
      zero_inputs();
      scan_dump();

      // Fully random mix of modes
      for (int k = 0; k < 300; k++) begin
         rand_inputs();
         step(($urandom_range(0, 19) != 0), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      end
      zero_inputs();
      scan_dump();

      @(negedge CK);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
